sdram_port_arbiter: RTL and testbench

- Shares the single FPGA-to-HPS SDRAM Avalon-MM burst port between two masters.
- Master A is the display frame-buffer reader: read-only, high priority.
- Master B is a general read/write client, such as a rasterizer or test writer.
- Sits between the masters and the HPS f2h_sdram0 port. It serialises commands, locks the grant for whole write bursts, and routes returning read beats to the master that issued them.

---
 rtl/sdram_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-master arbiter for the f2h_sdram0 Avalon-MM burst port
// A (display reader) has priority; B (read/write client) is protected from starvation.
module sdram_port_arbiter #(
    parameter int ADDR_WIDTH   = 29,
    parameter int DATA_WIDTH   = 64,
    parameter int BURST_WIDTH  = 8,
    parameter int TAG_DEPTH    = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [ADDR_WIDTH-1:0]     a_address,
    input  logic [BURST_WIDTH-1:0]    a_burstcount,
    input  logic                      a_read,
    output logic                      a_waitrequest,
    output logic                      a_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]     b_address,
    input  logic [BURST_WIDTH-1:0]    b_burstcount,
    input  logic                      b_read,
    input  logic                      b_write,
    input  logic [DATA_WIDTH-1:0]     b_writedata,
    input  logic [DATA_WIDTH/8-1:0]   b_byteenable,
    output logic                      b_waitrequest,
    output logic                      b_readdatavalid,
    output logic [ADDR_WIDTH-1:0]     m_address,
    output logic [BURST_WIDTH-1:0]    m_burstcount,
    output logic                      m_read,
    output logic                      m_write,
    output logic [DATA_WIDTH-1:0]     m_writedata,
    output logic [DATA_WIDTH/8-1:0]   m_byteenable,
    input  logic                      m_waitrequest,
    input  logic                      m_readdatavalid
);

    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, WBURST} state_t;

    typedef struct packed {
        logic                   owner_b;
        logic [BURST_WIDTH-1:0] beats;
    } tag_t;

    state_t                 state_q, state_d;
    tag_t                   tag_q [TAG_DEPTH];
    tag_t                   tag_d [TAG_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [STV_W-1:0]       starve_q, starve_d;
    logic [BURST_WIDTH-1:0] wcnt_q, wcnt_d, wburst_q, wburst_d;
    logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;

    logic                   full, empty, accept, push, do_push, beat, pop;
    logic                   b_req, a_elig, b_elig;
    logic [BURST_WIDTH-1:0] bc_a, bc_b;
    tag_t                   push_tag, head;

    always_comb begin
        full   = (count_q == CNT_W'(TAG_DEPTH));
        empty  = (count_q == '0);
        bc_a   = (a_burstcount == '0) ? BURST_WIDTH'(1) : a_burstcount;
        bc_b   = (b_burstcount == '0) ? BURST_WIDTH'(1) : b_burstcount;
        b_req  = b_read | b_write;
        a_elig = a_read & ~full;
        b_elig = b_write | (b_read & ~full);

        m_address       = '0;
        m_burstcount    = '0;
        m_read          = 1'b0;
        m_write         = 1'b0;
        m_writedata     = '0;
        m_byteenable    = '0;
        a_waitrequest   = 1'b1;
        b_waitrequest   = 1'b1;
        case (state_q)
            GRANT_A: begin
                m_address     = a_address;
                m_burstcount  = a_burstcount;
                m_read        = a_read;
                a_waitrequest = m_waitrequest;
            end
            GRANT_B: begin
                m_address     = b_address;
                m_burstcount  = b_burstcount;
                m_write       = b_write;
                m_read        = b_read & ~b_write;
                m_writedata   = b_writedata;
                m_byteenable  = b_byteenable;
                b_waitrequest = m_waitrequest;
            end
            WBURST: begin
                m_address     = waddr_q;
                m_burstcount  = wburst_q;
                m_write       = b_write;
                m_writedata   = b_writedata;
                m_byteenable  = b_byteenable;
                b_waitrequest = m_waitrequest;
            end
            default: ;
        endcase
        accept = (m_read | m_write) & ~m_waitrequest;

        state_d  = state_q;
        push     = 1'b0;
        push_tag = '0;
        wcnt_d   = wcnt_q;
        waddr_d  = waddr_q;
        wburst_d = wburst_q;
        case (state_q)
            IDLE: begin
                if ((starve_q == STV_W'(STARVE_LIMIT)) && b_elig) state_d = GRANT_B;
                else if (a_elig)                                    state_d = GRANT_A;
                else if (b_elig)                                    state_d = GRANT_B;
            end
            GRANT_A: begin
                if (accept) begin
                    push     = 1'b1;
                    push_tag = '{owner_b: 1'b0, beats: bc_a};
                    state_d  = IDLE;
                end else if (!a_read) begin
                    state_d = IDLE;
                end
            end
            GRANT_B: begin
                if (accept) begin
                    state_d = IDLE;
                    if (m_read) begin
                        push     = 1'b1;
                        push_tag = '{owner_b: 1'b1, beats: bc_b};
                    end else if (bc_b > BURST_WIDTH'(1)) begin
                        wcnt_d   = bc_b - BURST_WIDTH'(1);
                        waddr_d  = b_address;
                        wburst_d = b_burstcount;
                        state_d  = WBURST;
                    end
                end else if (!b_req) begin
                    state_d = IDLE;
                end
            end
            WBURST: begin
                if (accept) begin
                    wcnt_d = wcnt_q - BURST_WIDTH'(1);
                    if (wcnt_d == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        starve_d = starve_q;
        if (state_q == IDLE && state_d == GRANT_B)
            starve_d = '0;
        else if (b_req && state_q != GRANT_B && state_q != WBURST && starve_q < STV_W'(STARVE_LIMIT))
            starve_d = starve_q + STV_W'(1);

        // Head tag counts down the beats of the oldest read burst still returning.
        head            = tag_q[rd_ptr_q];
        beat            = m_readdatavalid & ~empty;
        a_readdatavalid = beat & ~head.owner_b;
        b_readdatavalid = beat & head.owner_b;
        pop             = beat & (head.beats <= BURST_WIDTH'(1));
        do_push         = push & (~full | pop);

        tag_d    = tag_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (beat && !pop) tag_d[rd_ptr_q].beats = head.beats - BURST_WIDTH'(1);
        if (pop)
            rd_ptr_d = (rd_ptr_q == PTR_W'(TAG_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        if (do_push) begin
            tag_d[wr_ptr_q] = push_tag;
            wr_ptr_d = (wr_ptr_q == PTR_W'(TAG_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            tag_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            wcnt_q   <= '0;
            waddr_q  <= '0;
            wburst_q <= '0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            wcnt_q   <= wcnt_d;
            waddr_q  <= waddr_d;
            wburst_q <= wburst_d;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [28:0] a_address, b_address, m_address;
    logic [7:0]  a_burstcount, b_burstcount, m_burstcount;
    logic        a_read, a_waitrequest, a_readdatavalid;
    logic        b_read, b_write, b_waitrequest, b_readdatavalid;
    logic [63:0] b_writedata, m_writedata;
    logic [7:0]  b_byteenable, m_byteenable;
    logic        m_read, m_write, m_waitrequest, m_readdatavalid;

    int n_cmp = 0;
    int n_err = 0;
    int beats, a_bad, addr_bad, data_bad, a_cnt, b_cnt;
    logic tog;

    always #5 clock = ~clock;

    sdram_port_arbiter #(
        .ADDR_WIDTH(29), .DATA_WIDTH(64), .BURST_WIDTH(8), .TAG_DEPTH(4), .STARVE_LIMIT(4)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .a_address(a_address), .a_burstcount(a_burstcount), .a_read(a_read),
        .a_waitrequest(a_waitrequest), .a_readdatavalid(a_readdatavalid),
        .b_address(b_address), .b_burstcount(b_burstcount), .b_read(b_read), .b_write(b_write),
        .b_writedata(b_writedata), .b_byteenable(b_byteenable),
        .b_waitrequest(b_waitrequest), .b_readdatavalid(b_readdatavalid),
        .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        a_address = '0; a_burstcount = '0; a_read = 1'b0;
        b_address = '0; b_burstcount = '0; b_read = 1'b0; b_write = 1'b0;
        b_writedata = '0; b_byteenable = '0;
        m_waitrequest = 1'b0; m_readdatavalid = 1'b1;
        step(); step();

        // reset state
        chk1("rst_m_read", m_read, 1'b0);
        chk1("rst_m_write", m_write, 1'b0);
        chk1("rst_a_wait", a_waitrequest, 1'b1);
        chk1("rst_b_wait", b_waitrequest, 1'b1);
        chk1("rst_a_rdv", a_readdatavalid, 1'b0);
        chk1("rst_b_rdv", b_readdatavalid, 1'b0);
        chkw("rst_m_addr", 64'(m_address), 64'h0);
        chkw("rst_m_bc", 64'(m_burstcount), 64'h0);
        chkw("rst_m_wd", m_writedata, 64'h0);
        chkw("rst_m_be", 64'(m_byteenable), 64'h0);
        reset_n = 1'b1; m_readdatavalid = 1'b0;
        step();

        // A reads 8 beats alone
        a_read = 1'b1; a_address = 29'h0700_0000; a_burstcount = 8'd8;
        #1;
        chk1("t1_idle_a_wait", a_waitrequest, 1'b1);
        chk1("t1_idle_m_read", m_read, 1'b0);
        step();
        chk1("t1_grant_m_read", m_read, 1'b1);
        chk1("t1_grant_a_wait", a_waitrequest, 1'b0);
        chk1("t1_grant_b_wait", b_waitrequest, 1'b1);
        chkw("t1_m_addr", 64'(m_address), 64'h0700_0000);
        chkw("t1_m_bc", 64'(m_burstcount), 64'd8);
        step();
        a_read = 1'b0;
        a_cnt = 0; b_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            m_readdatavalid = 1'b1;
            #1;
            if (a_readdatavalid) a_cnt++;
            if (b_readdatavalid) b_cnt++;
            step();
        end
        m_readdatavalid = 1'b1;
        #1;
        chk1("t1_empty_a_rdv", a_readdatavalid, 1'b0);
        chk1("t1_empty_b_rdv", b_readdatavalid, 1'b0);
        step();
        m_readdatavalid = 1'b0;
        chkw("t1_a_beats", 64'(a_cnt), 64'd8);
        chkw("t1_b_beats", 64'(b_cnt), 64'd0);

        // A and B read together: A first, then B; returns split 4/2
        a_read = 1'b1; a_address = 29'h100; a_burstcount = 8'd4;
        b_read = 1'b1; b_address = 29'h200; b_burstcount = 8'd2;
        #1;
        step();
        chk1("t2_a_grant", a_waitrequest, 1'b0);
        chk1("t2_b_stall", b_waitrequest, 1'b1);
        chkw("t2_a_addr", 64'(m_address), 64'h100);
        step();
        a_read = 1'b0;
        #1;
        chk1("t2_idle_b_wait", b_waitrequest, 1'b1);
        chk1("t2_idle_m_read", m_read, 1'b0);
        step();
        chk1("t2_b_grant", b_waitrequest, 1'b0);
        chk1("t2_a_stall", a_waitrequest, 1'b1);
        chk1("t2_b_m_read", m_read, 1'b1);
        chkw("t2_b_addr", 64'(m_address), 64'h200);
        chkw("t2_b_bc", 64'(m_burstcount), 64'd2);
        step();
        b_read = 1'b0;
        for (int i = 0; i < 6; i++) begin
            m_readdatavalid = 1'b1;
            #1;
            chk1("t2_a_rdv", a_readdatavalid, (i < 4));
            chk1("t2_b_rdv", b_readdatavalid, (i >= 4));
            step();
        end
        m_readdatavalid = 1'b0;

        // B write burst 16 with toggling waitrequest while A keeps requesting
        b_write = 1'b1; b_address = 29'h300; b_burstcount = 8'd16;
        b_writedata = 64'd0; b_byteenable = 8'hFF;
        #1;
        step();
        a_read = 1'b1; a_address = 29'h400; a_burstcount = 8'd1;
        tog = 1'b1; beats = 0; a_bad = 0; addr_bad = 0; data_bad = 0;
        for (int c = 0; c < 64 && beats < 16; c++) begin
            m_waitrequest = tog;
            tog = ~tog;
            b_writedata = 64'(beats);
            if (beats > 0) b_address = 29'h3FF;
            #1;
            if (a_waitrequest !== 1'b1) a_bad++;
            if (m_address !== 29'h300 || m_burstcount !== 8'd16) addr_bad++;
            if (m_writedata !== 64'(beats) || m_write !== 1'b1) data_bad++;
            if (m_write && !m_waitrequest) beats++;
            step();
        end
        b_write = 1'b0; m_waitrequest = 1'b0; b_address = 29'h300;
        #1;
        chk1("t3_done_m_write", m_write, 1'b0);
        chk1("t3_done_a_wait", a_waitrequest, 1'b1);
        chkw("t3_beats", 64'(beats), 64'd16);
        chkw("t3_a_stall_viol", 64'(a_bad), 64'd0);
        chkw("t3_addr_hold_viol", 64'(addr_bad), 64'd0);
        chkw("t3_data_viol", 64'(data_bad), 64'd0);
        step();
        chk1("t3_a_grant_after", a_waitrequest, 1'b0);
        chkw("t3_a_addr", 64'(m_address), 64'h400);
        step();
        a_read = 1'b0;
        m_readdatavalid = 1'b1;
        #1;
        chk1("t3_a_rdv", a_readdatavalid, 1'b1);
        step();
        m_readdatavalid = 1'b0;

        // starvation override at limit 4, then counter cleared
        a_read = 1'b1; a_address = 29'h500; a_burstcount = 8'd1;
        b_write = 1'b1; b_address = 29'h600; b_burstcount = 8'd1; b_writedata = 64'h55;
        #1;
        step();
        chk1("t4_a_grant1", a_waitrequest, 1'b0);
        chk1("t4_b_wait1", b_waitrequest, 1'b1);
        step();
        chk1("t4_idle2_a_wait", a_waitrequest, 1'b1);
        step();
        chk1("t4_a_grant2", a_waitrequest, 1'b0);
        step();
        chk1("t4_idle4_b_wait", b_waitrequest, 1'b1);
        step();
        chk1("t4_b_override", b_waitrequest, 1'b0);
        chk1("t4_b_a_stall", a_waitrequest, 1'b1);
        chk1("t4_b_m_write", m_write, 1'b1);
        chkw("t4_b_addr", 64'(m_address), 64'h600);
        step();
        step();
        chk1("t4_starve_cleared", a_waitrequest, 1'b0);
        chk1("t4_starve_cleared_b", b_waitrequest, 1'b1);
        step();
        b_write = 1'b0;

        // tag FIFO full: 4th read fills it, 5th waits for a pop, write still granted
        a_address = 29'h700;
        #1;
        step();
        chk1("t5_read4_grant", a_waitrequest, 1'b0);
        step();
        a_address = 29'h800;
        b_write = 1'b1; b_address = 29'h900; b_burstcount = 8'd1;
        #1;
        step();
        chk1("t5_write_when_full", b_waitrequest, 1'b0);
        chk1("t5_write_a_stall", a_waitrequest, 1'b1);
        chk1("t5_write_m_write", m_write, 1'b1);
        chkw("t5_write_addr", 64'(m_address), 64'h900);
        step();
        b_write = 1'b0;
        #1;
        chk1("t5_full_a_wait1", a_waitrequest, 1'b1);
        step();
        chk1("t5_full_a_wait2", a_waitrequest, 1'b1);
        chk1("t5_full_m_read", m_read, 1'b0);
        m_readdatavalid = 1'b1;
        #1;
        chk1("t5_pop_a_rdv", a_readdatavalid, 1'b1);
        step();
        m_readdatavalid = 1'b0;
        #1;
        chk1("t5_post_pop_idle", a_waitrequest, 1'b1);
        step();
        chk1("t5_read5_grant", a_waitrequest, 1'b0);
        chkw("t5_read5_addr", 64'(m_address), 64'h800);
        step();
        a_read = 1'b0;

        // drain two, then reset mid write burst with two reads outstanding
        for (int i = 0; i < 2; i++) begin
            m_readdatavalid = 1'b1;
            #1;
            chk1("t6_drain_a_rdv", a_readdatavalid, 1'b1);
            step();
        end
        m_readdatavalid = 1'b0;
        b_write = 1'b1; b_address = 29'hA00; b_burstcount = 8'd4;
        #1;
        step();
        step();
        step();
        chk1("t6_in_burst_m_write", m_write, 1'b1);
        chkw("t6_in_burst_addr", 64'(m_address), 64'hA00);
        reset_n = 1'b0;
        #1;
        chk1("t6_rst_m_write", m_write, 1'b0);
        chk1("t6_rst_a_wait", a_waitrequest, 1'b1);
        chk1("t6_rst_b_wait", b_waitrequest, 1'b1);
        chkw("t6_rst_m_addr", 64'(m_address), 64'h0);
        step();
        reset_n = 1'b1; b_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_readdatavalid = 1'b1;
            #1;
            chk1("t6_post_rst_a_rdv", a_readdatavalid, 1'b0);
            chk1("t6_post_rst_b_rdv", b_readdatavalid, 1'b0);
            step();
        end
        m_readdatavalid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
